bus_matrix: RTL and testbench

BUS_MATRIX -- requirements
Module: bus_matrix

---
 rtl/bus_pkg.sv | 21 ++
 rtl/bus_rr_arbiter.sv | 105 ++++++++++
 rtl/bus_matrix.sv | 80 ++++++++
 tb/tb_bus_matrix.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared defaults, arbiter state type and decode-error read pattern for the bus matrix.
package bus_pkg;

    localparam int N_MASTER_DEF = 4;
    localparam int N_SLAVE_DEF  = 4;
    localparam int AW_DEF       = 8;
    localparam int DW_DEF       = 32;
    localparam int SPAN_W_DEF   = 5;
    localparam int HOLD_MAX_DEF = 8;

    // Hold counter width; HOLD_MAX must stay below 2**HOLD_W.
    localparam int HOLD_W = 8;

    localparam logic [63:0] DECERR_DATA = '1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with a hold limit; last_owner doubles as the current owner while owned.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int N_MASTER = N_MASTER_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF,
    localparam int IW      = $clog2(N_MASTER)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_MASTER-1:0] req_i,
    output logic [N_MASTER-1:0] grant_o,
    output logic                own_o,
    output logic [IW-1:0]       owner_o
);

    localparam logic [HOLD_W-1:0] HOLD_SAT =
        (HOLD_MAX > 0) ? HOLD_W'(HOLD_MAX - 1) : {HOLD_W{1'b1}};

    arb_state_e            state_q, state_d;
    logic [N_MASTER-1:0]   grant_q, grant_d;
    logic [IW-1:0]         last_q, last_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [IW:0]           pickAll, pickOthers;
    logic                  holdLimit;

    // Returns {found, index} of the first request strictly after 'last', wrapping.
    function automatic logic [IW:0] rrPick(input logic [N_MASTER-1:0] req,
                                           input logic [IW-1:0] last);
        logic          found;
        logic [IW-1:0] idx;
        int            cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_MASTER; k++) begin
            cand = (int'(last) + k) % N_MASTER;
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        hold_d     = hold_q;
        grant_d    = '0;
        pickAll    = rrPick(req_i, last_q);
        pickOthers = rrPick(req_i & ~grant_q, last_q);
        holdLimit  = (HOLD_MAX > 0) && (hold_q == HOLD_SAT);
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (pickAll[IW]) begin
                    state_d = OWN;
                    last_d  = pickAll[IW-1:0];
                end
            end
            OWN: begin
                if (req_i[last_q]) begin
                    if (holdLimit && pickOthers[IW]) begin
                        last_d = pickOthers[IW-1:0];
                        hold_d = '0;
                    end else if (hold_q != HOLD_SAT) begin
                        hold_d = hold_q + 1'b1;
                    end
                end else if (pickOthers[IW]) begin
                    last_d = pickOthers[IW-1:0];
                    hold_d = '0;
                end else begin
                    state_d = IDLE;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
        if (state_d == OWN) begin
            grant_d[last_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            hold_q  <= '0;
            last_q  <= IW'(N_MASTER - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign grant_o = grant_q;
    assign own_o   = (state_q == OWN);
    assign owner_o = last_q;

endmodule

// File: rtl/bus_matrix.sv
// Shared-bus matrix: round-robin master arbitration, owner muxing and slave address decode.
// Define BUS_DECERR_EN to flag unmapped accesses on m_err and return all-ones read data.
module bus_matrix
    import bus_pkg::*;
#(
    parameter int N_MASTER = N_MASTER_DEF,
    parameter int N_SLAVE  = N_SLAVE_DEF,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int SPAN_W   = SPAN_W_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_MASTER-1:0]    m_req,
    input  logic [N_MASTER-1:0]    m_wr,
    input  logic [N_MASTER*AW-1:0] m_address,
    input  logic [N_MASTER*DW-1:0] m_dout,
    output logic [N_MASTER-1:0]    m_grant,
    output logic [DW-1:0]          m_din,
    output logic [N_SLAVE-1:0]     s_sel,
    output logic [AW-1:0]          s_address,
    output logic                   s_wr,
    output logic [DW-1:0]          s_din,
    input  logic [N_SLAVE*DW-1:0]  s_dout,
    output logic                   m_err
);

    localparam int IW = $clog2(N_MASTER);
    localparam int SW = AW - SPAN_W;

    logic          own;
    logic [IW-1:0] owner;
    logic [SW-1:0] slaveIdx;
    logic          mapped;

    bus_rr_arbiter #(
        .N_MASTER (N_MASTER),
        .HOLD_MAX (HOLD_MAX)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_i   (m_req),
        .grant_o (m_grant),
        .own_o   (own),
        .owner_o (owner)
    );

    always_comb begin
        s_address = '0;
        s_wr      = 1'b0;
        s_din     = '0;
        if (own) begin
            s_address = m_address[owner*AW +: AW];
            s_wr      = m_wr[owner];
            s_din     = m_dout[owner*DW +: DW];
        end
    end

    assign slaveIdx = s_address[AW-1:SPAN_W];
    assign mapped   = own && (int'(slaveIdx) < N_SLAVE);

    // Unmapped accesses select nothing; the error response only exists in the BUS_DECERR_EN build.
    always_comb begin
        s_sel = '0;
        m_din = '0;
        m_err = 1'b0;
        if (mapped) begin
            s_sel[slaveIdx] = 1'b1;
            m_din           = s_dout[slaveIdx*DW +: DW];
        end
`ifdef BUS_DECERR_EN
        else if (own) begin
            m_err = 1'b1;
            m_din = DECERR_DATA[DW-1:0];
        end
`endif
    end

endmodule

// File: tb/tb_bus_matrix.sv
// Scoreboard bench for bus_matrix: directed cycles push expectations, a negedge monitor pops and compares.
module tb_bus_matrix;

    localparam int NM = 4;
    localparam int NS = 2;
    localparam int AW = 8;
    localparam int DW = 32;

`ifdef BUS_DECERR_EN
    localparam logic [DW-1:0] UNMAP_DATA = 32'hFFFFFFFF;
    localparam logic          UNMAP_ERR  = 1'b1;
`else
    localparam logic [DW-1:0] UNMAP_DATA = 32'h00000000;
    localparam logic          UNMAP_ERR  = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic [NM-1:0]    m_req;
    logic [NM-1:0]    m_wr;
    logic [NM*AW-1:0] m_address;
    logic [NM*DW-1:0] m_dout;
    logic [NM-1:0]    m_grant;
    logic [DW-1:0]    m_din;
    logic [NS-1:0]    s_sel;
    logic [AW-1:0]    s_address;
    logic             s_wr;
    logic [DW-1:0]    s_din;
    logic [NS*DW-1:0] s_dout;
    logic             m_err;

    typedef struct {
        int            cyc;
        bit            grantOnly;
        logic [NM-1:0] grant;
        logic [NS-1:0] sel;
        logic          wr;
        logic [DW-1:0] din;
        logic [DW-1:0] mdin;
        logic          err;
    } exp_t;

    exp_t  expQ[$];
    string nameQ[$];
    exp_t  monExp;
    string monName;
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;

    bus_matrix #(
        .N_MASTER (NM),
        .N_SLAVE  (NS),
        .AW       (AW),
        .DW       (DW),
        .SPAN_W   (5),
        .HOLD_MAX (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_address (m_address),
        .m_dout    (m_dout),
        .m_grant   (m_grant),
        .m_din     (m_din),
        .s_sel     (s_sel),
        .s_address (s_address),
        .s_wr      (s_wr),
        .s_din     (s_din),
        .s_dout    (s_dout),
        .m_err     (m_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic applyStimulus(input logic [NM-1:0] req, input logic [NM-1:0] wr);
        @(posedge clk);
        #1;
        m_req = req;
        m_wr  = wr;
    endtask

    task automatic expectFull(input string name, input logic [NM-1:0] grant,
                              input logic [NS-1:0] sel, input logic wr,
                              input logic [DW-1:0] din, input logic [DW-1:0] mdin,
                              input logic err);
        exp_t e;
        e.cyc = cyc; e.grantOnly = 1'b0; e.grant = grant; e.sel = sel;
        e.wr = wr; e.din = din; e.mdin = mdin; e.err = err;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    task automatic expectGrant(input string name, input logic [NM-1:0] grant);
        exp_t e;
        e.cyc = cyc; e.grantOnly = 1'b1; e.grant = grant; e.sel = '0;
        e.wr = 1'b0; e.din = '0; e.mdin = '0; e.err = 1'b0;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cyc, actual, required);
        end
    endtask

    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
            monExp  = expQ.pop_front();
            monName = nameQ.pop_front();
            if (monExp.cyc != cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s: expectation for cycle %0d missed, now %0d", monName, monExp.cyc, cyc);
            end else begin
                checkOutput({monName, ".grant"}, 32'(m_grant), 32'(monExp.grant));
                if (!monExp.grantOnly) begin
                    checkOutput({monName, ".s_sel"}, 32'(s_sel), 32'(monExp.sel));
                    checkOutput({monName, ".s_wr"},  32'(s_wr),  32'(monExp.wr));
                    checkOutput({monName, ".s_din"}, s_din,      monExp.din);
                    checkOutput({monName, ".m_din"}, m_din,      monExp.mdin);
                    checkOutput({monName, ".m_err"}, 32'(m_err), 32'(monExp.err));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        m_req     = '0;
        m_wr      = '0;
        m_address = {8'h10, 8'h60, 8'h21, 8'h03};
        m_dout    = {32'h44444444, 32'h22222222, 32'h11111111, 32'h33333333};
        s_dout    = {32'h23231111, 32'h5A5A0000};

        applyStimulus(4'b0000, 4'b0000);
        expectFull("reset1", 4'b0000, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(4'b0000, 4'b0000);
        expectFull("reset2", 4'b0000, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);

        applyStimulus(4'b0001, 4'b0001);
        reset = 1'b0;
        expectFull("reqSampled", 4'b0000, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(4'b0001, 4'b0001);
        expectFull("m0Write", 4'b0001, 2'b01, 1'b1, 32'h33333333, 32'h5A5A0000, 1'b0);

        applyStimulus(4'b0001, 4'b0000);
        m_address[7:0] = 8'h21;
        expectFull("m0Read", 4'b0001, 2'b10, 1'b0, 32'h33333333, 32'h23231111, 1'b0);

        applyStimulus(4'b0100, 4'b0000);
        expectFull("dropRaise", 4'b0001, 2'b10, 1'b0, 32'h33333333, 32'h23231111, 1'b0);
        applyStimulus(4'b0100, 4'b0000);
        expectFull("handover", 4'b0100, 2'b00, 1'b0, 32'h22222222, UNMAP_DATA, UNMAP_ERR);
        applyStimulus(4'b0000, 4'b0000);
        expectFull("unmapped", 4'b0100, 2'b00, 1'b0, 32'h22222222, UNMAP_DATA, UNMAP_ERR);
        applyStimulus(4'b0000, 4'b0000);
        expectFull("toIdle", 4'b0000, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);

        applyStimulus(4'b0010, 4'b0010);
        expectFull("m1Req", 4'b0000, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(4'b0010, 4'b0010);
        expectFull("m1Write", 4'b0010, 2'b10, 1'b1, 32'h11111111, 32'h23231111, 1'b0);
        applyStimulus(4'b0010, 4'b0010);
        reset = 1'b1;
        expectFull("m1Hold", 4'b0010, 2'b10, 1'b1, 32'h11111111, 32'h23231111, 1'b0);
        applyStimulus(4'b1111, 4'b0000);
        reset = 1'b0;
        expectFull("midReset", 4'b0000, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);

        for (int k = 0; k < 33; k++) begin
            logic [NM-1:0] g;
            applyStimulus(4'b1111, 4'b0000);
            g = NM'(1) << ((k / 8) % NM);
            if (k == 0)
                expectFull("firstAfterReset", g, 2'b10, 1'b0, 32'h33333333, 32'h23231111, 1'b0);
            else
                expectGrant("rotate", g);
        end

        applyStimulus(4'b0000, 4'b0000);
        applyStimulus(4'b0000, 4'b0000);
        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: %0d expectations left, expected 0", expQ.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
